// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// bubble instruction and sequential PC arithmetic.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;
    localparam logic [31:0] PC_STEP         = 32'd4;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id.sv
// IF/ID pipeline register: holds when disabled, loads a bubble on clear.
module if_id_register
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTRUCTION
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_plus4_d,
    output logic [31:0] instr_q,
    output logic [31:0] pc_plus4_q,
    output logic        valid_q
);

    // Pipeline register with synchronous reset, hold and bubble insertion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else if (enable) begin
            if (clear) begin
                instr_q    <= NOP_INSTR;
                pc_plus4_q <= 32'h0000_0000;
                valid_q    <= 1'b0;
            end else begin
                instr_q    <= instr_d;
                pc_plus4_q <= pc_plus4_d;
                valid_q    <= 1'b1;
            end
        end else begin
            instr_q    <= instr_q;
            pc_plus4_q <= pc_plus4_q;
            valid_q    <= valid_q;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request/ack FSM, hold buffer and IF/ID register.
// Build option DELAY_SLOT_EN delivers the instruction after a branch/jump.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTRUCTION
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_fetch,
    input  logic        stall_decode,
    input  logic        pc_src_decode,
    input  logic        jump_decode,
    input  logic [31:0] branch_target_decode,
    input  logic [31:0] jump_target_decode,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_decode,
    output logic [31:0] pc_plus4_decode,
    output logic        valid_decode,
    output logic        imem_stall
);

    fetch_state_t state_r, state_next_s;
    logic [31:0]  pc_r, pc_next_s;
    logic [31:0]  hold_buf_r, hold_buf_next_s;
    logic [31:0]  discard_addr_r, discard_addr_next_s;
    logic         redirect_s;
    logic [31:0]  target_s;
    logic         deliver_s;
    logic [31:0]  deliver_instr_s;
    logic [31:0]  deliver_pc4_s;
    logic         bubble_s;

    // Redirect decode: a stalled decode stage must not steer fetch.
    always_comb begin
        redirect_s = (jump_decode | pc_src_decode) & ~stall_decode;
        if (jump_decode) begin
            target_s = jump_target_decode;
        end else begin
            target_s = branch_target_decode;
        end
    end

    // Next-state, next-PC and delivery selection.
    always_comb begin
        state_next_s        = state_r;
        pc_next_s           = pc_r;
        hold_buf_next_s     = hold_buf_r;
        discard_addr_next_s = discard_addr_r;
        deliver_s           = 1'b0;
        deliver_instr_s     = NOP_INSTR;
        deliver_pc4_s       = next_seq_pc(pc_r);
        case (state_r)
            FETCH: begin
                if (redirect_s) begin
                    pc_next_s = target_s;
`ifdef DELAY_SLOT_EN
                    if (imem_ack) begin
                        deliver_s       = 1'b1;
                        deliver_instr_s = imem_rdata;
                    end else begin
                        state_next_s        = DISCARD;
                        discard_addr_next_s = pc_r;
                    end
`else
                    if (imem_ack) begin
                        state_next_s = FETCH;
                    end else begin
                        state_next_s        = DISCARD;
                        discard_addr_next_s = pc_r;
                    end
`endif
                end else if (imem_ack) begin
                    if (stall_fetch) begin
                        hold_buf_next_s = imem_rdata;
                        state_next_s    = HOLD;
                    end else begin
                        deliver_s       = 1'b1;
                        deliver_instr_s = imem_rdata;
                        pc_next_s       = next_seq_pc(pc_r);
                    end
                end else begin
                    state_next_s = FETCH;
                end
            end
            HOLD: begin
                if (redirect_s) begin
                    pc_next_s       = target_s;
                    hold_buf_next_s = NOP_INSTR;
                    state_next_s    = FETCH;
`ifdef DELAY_SLOT_EN
                    deliver_s       = 1'b1;
                    deliver_instr_s = hold_buf_r;
`endif
                end else if (!stall_fetch) begin
                    deliver_s       = 1'b1;
                    deliver_instr_s = hold_buf_r;
                    pc_next_s       = next_seq_pc(pc_r);
                    state_next_s    = FETCH;
                end else begin
                    state_next_s = HOLD;
                end
            end
            DISCARD: begin
                // The outstanding request still targets the pre-redirect address.
                if (redirect_s) begin
                    pc_next_s = target_s;
                end else begin
                    pc_next_s = pc_r;
                end
                if (imem_ack) begin
                    state_next_s = FETCH;
`ifdef DELAY_SLOT_EN
                    deliver_s       = 1'b1;
                    deliver_instr_s = imem_rdata;
                    deliver_pc4_s   = next_seq_pc(discard_addr_r);
`endif
                end else begin
                    state_next_s = DISCARD;
                end
            end
            default: begin
                state_next_s = FETCH;
            end
        endcase
    end

    // Redirect squashes any delivery unless the delay slot is architected.
    always_comb begin
`ifdef DELAY_SLOT_EN
        bubble_s = ~deliver_s;
`else
        bubble_s = ~deliver_s | redirect_s;
`endif
    end

    // Fetch state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r        <= FETCH;
            pc_r           <= RESET_PC;
            hold_buf_r     <= 32'h0000_0000;
            discard_addr_r <= RESET_PC;
        end else begin
            state_r        <= state_next_s;
            pc_r           <= pc_next_s;
            hold_buf_r     <= hold_buf_next_s;
            discard_addr_r <= discard_addr_next_s;
        end
    end

    // Memory request interface, quiet while reset is held.
    always_comb begin
        if (!reset_n) begin
            imem_req   = 1'b0;
            imem_addr  = RESET_PC;
            imem_stall = 1'b1;
        end else begin
            imem_req   = (state_r == FETCH) | (state_r == DISCARD);
            imem_stall = ((state_r == FETCH) & ~imem_ack) | (state_r == DISCARD);
            if (state_r == DISCARD) begin
                imem_addr = discard_addr_r;
            end else begin
                imem_addr = pc_r;
            end
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (~stall_decode),
        .clear      (bubble_s),
        .instr_d    (deliver_instr_s),
        .pc_plus4_d (deliver_pc4_s),
        .instr_q    (instruction_decode),
        .pc_plus4_q (pc_plus4_decode),
        .valid_q    (valid_decode)
    );

endmodule
